// File: rtl/checksum_pkg.sv
// Shared types and ones-complement helpers for the streaming Internet
// checksum engine.
//   csum_t        : 16-bit ones-complement partial sum
//   CSUM_ALL_ONES : sum value of a frame that verifies
//   oc_add16      : 16-bit add with end-around carry
//   bswap16       : swap the two bytes of a 16-bit word
package checksum_pkg;

    typedef logic [15:0] csum_t;

    localparam csum_t CSUM_ALL_ONES = 16'hFFFF;

    // The end-around carry cannot overflow again: the largest low half after
    // a carry-out is 0xFFFE.
    function automatic csum_t oc_add16(input csum_t a, input csum_t b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    function automatic csum_t bswap16(input csum_t v);
        return {v[7:0], v[15:8]};
    endfunction

endpackage

// File: rtl/checksum_beat_sum.sv
// Combinational ones-complement sum of one beat.
// Bytes beyond cnt are masked to zero, the beat is summed as big-endian
// 16-bit words aligned at the MSB byte, and the result is folded to 16 bits.
// A trailing odd byte lands in the high half of its word.
//   data : DATA_BYTES bytes, MSB byte first on the wire
//   cnt  : valid byte count, already clamped to DATA_BYTES
//   sum  : folded 16-bit sum of the valid bytes
module checksum_beat_sum
    import checksum_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int CNT_W      = $clog2(DATA_BYTES + 1)
) (
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic [CNT_W-1:0]        cnt,
    output csum_t                   sum
);

    // Eight words of 0xFFFF at most (16 bytes) fit comfortably in 24 bits.
    logic [23:0] raw;
    logic [16:0] fold1;

    always_comb begin
        logic [7:0] b;
        raw = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            b = data[8*(DATA_BYTES-1-i) +: 8];
            if (i < 32'(cnt)) begin
                if ((i % 2) == 0) begin
                    raw = raw + {8'd0, b, 8'd0};
                end else begin
                    raw = raw + {16'd0, b};
                end
            end
        end
        // Two folds: the first may carry once more into bit 16, the second
        // cannot.
        fold1 = {1'b0, raw[15:0]} + {9'd0, raw[23:16]};
        sum   = fold1[15:0] + {15'd0, fold1[16]};
    end

endmodule

// File: rtl/checksum_stream.sv
// Streaming RFC 1071 ones-complement checksum engine.
// Two register stages: stage 1 sums and byte-aligns one beat, stage 2
// accumulates into the frame sum and registers the framed result.
//   clk       : clock
//   clr       : synchronous active-high reset, aborts any open frame
//   seed      : initial partial sum, sampled on the first beat of a frame
//   data_en   : beat valid (no backpressure)
//   data_in   : beat bytes, MSB byte first on the wire
//   data_cnt  : valid bytes in the beat, packed from the MSB (0 = empty)
//   data_last : last beat of the frame
//   sum_valid : one-cycle result pulse
//   checksum  : complemented frame sum (0x0000 -> 0xFFFF when ZERO_AS_FFFF)
//   check_ok  : frame sum equals 0xFFFF
//   phase     : byte parity of the bytes accepted so far in the frame
//   in_frame  : first beat seen, last beat not yet accepted
module checksum_stream
    import checksum_pkg::*;
#(
    parameter int  DATA_BYTES   = 4,
    parameter bit  ZERO_AS_FFFF = 1'b0,
    localparam int CNT_W        = $clog2(DATA_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    clr,
    input  csum_t                   seed,
    input  logic                    data_en,
    input  logic [8*DATA_BYTES-1:0] data_in,
    input  logic [CNT_W-1:0]        data_cnt,
    input  logic                    data_last,
    output logic                    sum_valid,
    output csum_t                   checksum,
    output logic                    check_ok,
    output logic                    phase,
    output logic                    in_frame
);

    logic [CNT_W-1:0] cnt_c;
    csum_t            beat_fold;

    logic  s1_valid;
    logic  s1_first;
    logic  s1_last;
    csum_t s1_sum;
    csum_t s1_seed;

    csum_t acc;
    csum_t acc_next;
    csum_t csum_final;

    assign cnt_c = (data_cnt > CNT_W'(DATA_BYTES)) ? CNT_W'(DATA_BYTES) : data_cnt;

    checksum_beat_sum #(
        .DATA_BYTES (DATA_BYTES),
        .CNT_W      (CNT_W)
    ) u_beat_sum (
        .data (data_in),
        .cnt  (cnt_c),
        .sum  (beat_fold)
    );

    // Stage 1: a beat starting on an odd byte offset has its words straddling
    // the frame's word boundaries, so its folded sum is byte-swapped.
    always_ff @(posedge clk) begin
        if (clr) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_sum   <= '0;
            s1_seed  <= '0;
            phase    <= 1'b0;
            in_frame <= 1'b0;
        end else begin
            s1_valid <= data_en;
            if (data_en) begin
                s1_first <= ~in_frame;
                s1_last  <= data_last;
                s1_sum   <= phase ? bswap16(beat_fold) : beat_fold;
                if (!in_frame) begin
                    s1_seed <= seed;
                end
                phase    <= data_last ? 1'b0 : (phase ^ cnt_c[0]);
                in_frame <= ~data_last;
            end
        end
    end

    // Stage 2: a first beat restarts from its own captured seed, so a new
    // frame directly behind a closing one never sees the old accumulator.
    always_comb begin
        acc_next   = oc_add16(s1_first ? s1_seed : acc, s1_sum);
        csum_final = ~acc_next;
        if (ZERO_AS_FFFF && (csum_final == 16'h0000)) begin
            csum_final = CSUM_ALL_ONES;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            acc       <= '0;
            sum_valid <= 1'b0;
            checksum  <= CSUM_ALL_ONES;
            check_ok  <= 1'b0;
        end else begin
            sum_valid <= s1_valid & s1_last;
            if (s1_valid) begin
                acc <= acc_next;
            end
            if (s1_valid && s1_last) begin
                checksum <= csum_final;
                check_ok <= (acc_next == CSUM_ALL_ONES);
            end
        end
    end

endmodule

// File: tb/tb_checksum_stream.sv
module tb_checksum_stream;

    logic        clk;
    logic        clr;
    logic [15:0] seed;
    logic        data_en;
    logic [31:0] data_in;
    logic [2:0]  data_cnt;
    logic        data_last;

    logic        sum_valid, check_ok, phase, in_frame;
    logic [15:0] checksum;
    logic        sum_valid_z, check_ok_z, phase_z, in_frame_z;
    logic [15:0] checksum_z;

    int n_cmp = 0;
    int n_err = 0;

    checksum_stream #(.DATA_BYTES(4), .ZERO_AS_FFFF(1'b0)) u_dut (
        .clk       (clk),
        .clr       (clr),
        .seed      (seed),
        .data_en   (data_en),
        .data_in   (data_in),
        .data_cnt  (data_cnt),
        .data_last (data_last),
        .sum_valid (sum_valid),
        .checksum  (checksum),
        .check_ok  (check_ok),
        .phase     (phase),
        .in_frame  (in_frame)
    );

    checksum_stream #(.DATA_BYTES(4), .ZERO_AS_FFFF(1'b1)) u_dut_z (
        .clk       (clk),
        .clr       (clr),
        .seed      (seed),
        .data_en   (data_en),
        .data_in   (data_in),
        .data_cnt  (data_cnt),
        .data_last (data_last),
        .sum_valid (sum_valid_z),
        .checksum  (checksum_z),
        .check_ok  (check_ok_z),
        .phase     (phase_z),
        .in_frame  (in_frame_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one beat for one clock; afterwards the seed is scrambled so a
    // design that uses the live seed instead of the captured one is exposed.
    task automatic send(input logic [31:0] d, input logic [2:0] c, input logic l,
                        input logic [15:0] s);
        data_en   = 1'b1;
        data_in   = d;
        data_cnt  = c;
        data_last = l;
        seed      = s;
        @(posedge clk); #1;
        data_en   = 1'b0;
        data_in   = '0;
        data_cnt  = '0;
        data_last = 1'b0;
        seed      = 16'hDEAD;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL reset_sum_valid: got %b want 0", sum_valid); end
        n_cmp++; if (checksum !== 16'hFFFF) begin n_err++; $display("FAIL reset_checksum: got %h want ffff", checksum); end
        n_cmp++; if (check_ok !== 1'b0) begin n_err++; $display("FAIL reset_check_ok: got %b want 0", check_ok); end
        n_cmp++; if (phase !== 1'b0) begin n_err++; $display("FAIL reset_phase: got %b want 0", phase); end
        n_cmp++; if (in_frame !== 1'b0) begin n_err++; $display("FAIL reset_in_frame: got %b want 0", in_frame); end
        clr = 1'b0;
        tick();
    endtask

    task automatic test_single_beat();
        send(32'h0001F203, 3'd4, 1'b1, 16'h0000);
        n_cmp++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL single_early_pulse: got %b want 0", sum_valid); end
        tick();
        n_cmp++; if (sum_valid !== 1'b1) begin n_err++; $display("FAIL single_sum_valid: got %b want 1", sum_valid); end
        n_cmp++; if (checksum !== 16'h0DFB) begin n_err++; $display("FAIL single_checksum: got %h want 0dfb", checksum); end
        n_cmp++; if (check_ok !== 1'b0) begin n_err++; $display("FAIL single_check_ok: got %b want 0", check_ok); end
        tick();
        n_cmp++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL single_pulse_width: got %b want 0", sum_valid); end
        n_cmp++; if (checksum !== 16'h0DFB) begin n_err++; $display("FAIL single_hold: got %h want 0dfb", checksum); end
        // Count 7 exceeds the beat width and is treated as 4.
        send(32'h0001F203, 3'd7, 1'b1, 16'h0000);
        tick();
        n_cmp++; if (checksum !== 16'h0DFB) begin n_err++; $display("FAIL clamp_checksum: got %h want 0dfb", checksum); end
    endtask

    task automatic test_odd_length();
        send(32'h12345678, 3'd3, 1'b1, 16'h0000);
        n_cmp++; if (phase !== 1'b0) begin n_err++; $display("FAIL odd_phase_after: got %b want 0", phase); end
        n_cmp++; if (in_frame !== 1'b0) begin n_err++; $display("FAIL odd_in_frame: got %b want 0", in_frame); end
        tick();
        n_cmp++; if (sum_valid !== 1'b1) begin n_err++; $display("FAIL odd_sum_valid: got %b want 1", sum_valid); end
        n_cmp++; if (checksum !== 16'h97CB) begin n_err++; $display("FAIL odd_checksum: got %h want 97cb", checksum); end
    endtask

    task automatic test_phase();
        send(32'hAB000000, 3'd1, 1'b0, 16'h0000);
        n_cmp++; if (phase !== 1'b1) begin n_err++; $display("FAIL phase_mid: got %b want 1", phase); end
        n_cmp++; if (in_frame !== 1'b1) begin n_err++; $display("FAIL phase_in_frame: got %b want 1", in_frame); end
        repeat (3) tick();
        n_cmp++; if (phase !== 1'b1) begin n_err++; $display("FAIL phase_idle_hold: got %b want 1", phase); end
        n_cmp++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL phase_idle_pulse: got %b want 0", sum_valid); end
        send(32'hCDEF0000, 3'd2, 1'b1, 16'h0000);
        tick();
        n_cmp++; if (sum_valid !== 1'b1) begin n_err++; $display("FAIL phase_sum_valid: got %b want 1", sum_valid); end
        n_cmp++; if (checksum !== 16'h6531) begin n_err++; $display("FAIL phase_checksum: got %h want 6531", checksum); end
    endtask

    task automatic test_wrap_verify();
        send(32'h00030000, 3'd2, 1'b1, 16'hFFFE);
        tick();
        n_cmp++; if (checksum !== 16'hFFFD) begin n_err++; $display("FAIL wrap_checksum: got %h want fffd", checksum); end
        n_cmp++; if (check_ok !== 1'b0) begin n_err++; $display("FAIL wrap_check_ok: got %b want 0", check_ok); end
        send(32'h0001F203, 3'd4, 1'b0, 16'h0000);
        send(32'h0DFB0000, 3'd2, 1'b1, 16'h0000);
        tick();
        n_cmp++; if (sum_valid !== 1'b1) begin n_err++; $display("FAIL verify_sum_valid: got %b want 1", sum_valid); end
        n_cmp++; if (check_ok !== 1'b1) begin n_err++; $display("FAIL verify_check_ok: got %b want 1", check_ok); end
        n_cmp++; if (checksum !== 16'h0000) begin n_err++; $display("FAIL verify_checksum: got %h want 0000", checksum); end
        n_cmp++; if (sum_valid_z !== 1'b1) begin n_err++; $display("FAIL verify_z_sum_valid: got %b want 1", sum_valid_z); end
        n_cmp++; if (check_ok_z !== 1'b1) begin n_err++; $display("FAIL verify_z_check_ok: got %b want 1", check_ok_z); end
        n_cmp++; if (checksum_z !== 16'hFFFF) begin n_err++; $display("FAIL verify_z_checksum: got %h want ffff", checksum_z); end
    endtask

    task automatic test_back_to_back();
        send(32'h0001F203, 3'd4, 1'b1, 16'h0000);
        send(32'h12345678, 3'd3, 1'b1, 16'h0000);
        n_cmp++; if (sum_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first_valid: got %b want 1", sum_valid); end
        n_cmp++; if (checksum !== 16'h0DFB) begin n_err++; $display("FAIL b2b_first_checksum: got %h want 0dfb", checksum); end
        tick();
        n_cmp++; if (sum_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second_valid: got %b want 1", sum_valid); end
        n_cmp++; if (checksum !== 16'h97CB) begin n_err++; $display("FAIL b2b_second_checksum: got %h want 97cb", checksum); end
        tick();
        n_cmp++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL b2b_after: got %b want 0", sum_valid); end
    endtask

    task automatic test_clr_mid_frame();
        send(32'hAB000000, 3'd1, 1'b0, 16'h0000);
        do_clr();
        n_cmp++; if (in_frame !== 1'b0) begin n_err++; $display("FAIL clr_in_frame: got %b want 0", in_frame); end
        n_cmp++; if (phase !== 1'b0) begin n_err++; $display("FAIL clr_phase: got %b want 0", phase); end
        n_cmp++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL clr_no_pulse: got %b want 0", sum_valid); end
        send(32'h0001F203, 3'd4, 1'b1, 16'h0000);
        tick();
        n_cmp++; if (sum_valid !== 1'b1) begin n_err++; $display("FAIL clr_next_valid: got %b want 1", sum_valid); end
        n_cmp++; if (checksum !== 16'h0DFB) begin n_err++; $display("FAIL clr_next_checksum: got %h want 0dfb", checksum); end
        // Last beat already in stage 1 when clr hits: its result is dropped.
        send(32'hAB000000, 3'd1, 1'b0, 16'h0000);
        send(32'hCDEF0000, 3'd2, 1'b1, 16'h0000);
        do_clr();
        n_cmp++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_pulse: got %b want 0", sum_valid); end
        n_cmp++; if (checksum !== 16'hFFFF) begin n_err++; $display("FAIL flush_checksum: got %h want ffff", checksum); end
        tick();
        n_cmp++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL flush_late_pulse: got %b want 0", sum_valid); end
    endtask

    task automatic test_empty();
        send(32'h00000000, 3'd0, 1'b1, 16'h1234);
        tick();
        n_cmp++; if (sum_valid !== 1'b1) begin n_err++; $display("FAIL empty_sum_valid: got %b want 1", sum_valid); end
        n_cmp++; if (checksum !== 16'hEDCB) begin n_err++; $display("FAIL empty_checksum: got %h want edcb", checksum); end
        send(32'hAB000000, 3'd1, 1'b0, 16'h0000);
        send(32'hFFFFFFFF, 3'd0, 1'b0, 16'h0000);
        n_cmp++; if (phase !== 1'b1) begin n_err++; $display("FAIL empty_mid_phase: got %b want 1", phase); end
        send(32'hCDEF0000, 3'd2, 1'b1, 16'h0000);
        tick();
        n_cmp++; if (checksum !== 16'h6531) begin n_err++; $display("FAIL empty_mid_checksum: got %h want 6531", checksum); end
    endtask

    initial begin
        clr       = 1'b1;
        seed      = '0;
        data_en   = 1'b0;
        data_in   = '0;
        data_cnt  = '0;
        data_last = 1'b0;

        test_reset();
        test_single_beat();
        test_odd_length();
        test_phase();
        test_wrap_verify();
        test_back_to_back();
        test_clr_mid_frame();
        test_empty();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
